// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the M-stage memory access controller: FSM encoding,
// funct3 access codes and the helpers that shape bus qualifiers.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   // funct3[1:0] carries the size for both signed and unsigned forms.
   function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~a[0];
         default: ok = (a == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << {a[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] replicate_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load lane select and sign/zero extension for byte, halfword and word loads.
module load_extend
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_HU:   o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store bus controller: stalls the pipeline while one request/grant/
// response transaction runs on a simple bus, with alignment check and timeout abort.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic        StallMem,
   output logic [31:0] ReadDataM,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_bus_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [2:0]  r_funct3;
   logic [31:0] r_rdata;
   logic        r_bus_err;

   logic        w_aligned;
   logic        w_start;
   logic        w_timeout;
   logic [31:0] w_ext;

   assign w_aligned = access_aligned(Funct3M, ALUResultM[1:0]);
   assign w_start   = (r_state == S_IDLE) && MemReqM && w_aligned;
   // Compared with >= so a grant on the last REQ cycle still aborts promptly in WAIT.
   assign w_timeout = (r_cnt >= LAST_CNT);

   // NOTE: the IDLE term is combinational so the pipeline freezes in the same cycle the request appears.
   assign StallMem  = w_start || (r_state == S_REQ) || (r_state == S_WAIT);
   assign MisalignM = (r_state == S_IDLE) && MemReqM && !w_aligned;

   assign ReadDataM = r_rdata;
   assign BusErrM   = r_bus_err;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_be    = r_be;

   load_extend u_load_extend (
      .i_rdata   (bus_rdata),
      .i_addr_lo (r_addr[1:0]),
      .i_funct3  (r_funct3),
      .o_data    (w_ext)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_bus_req <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_be      <= 4'd0;
         r_funct3  <= 3'd0;
         r_rdata   <= 32'd0;
         r_bus_err <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_bus_err <= 1'b0;
               if (w_start) begin
                  r_we      <= MemWriteM;
                  r_addr    <= ALUResultM;
                  r_be      <= byte_enables(Funct3M, ALUResultM[1:0]);
                  r_wdata   <= replicate_wdata(Funct3M, WriteDataM);
                  r_funct3  <= Funct3M;
                  r_cnt     <= 8'd0;
                  r_bus_req <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 8'd1;
               if (bus_gnt) begin
                  r_bus_req <= 1'b0;
                  r_state   <= r_we ? S_DONE : S_WAIT;
               end else if (w_timeout) begin
                  r_bus_req <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_state   <= S_DONE;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (bus_rvalid) begin
                  r_rdata <= w_ext;
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_bus_err <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
